pipeline_sequencer: RTL

Stall/flush sequencer for the 5-stage ARM-style pipeline. It consumes decode-stage register usage, EX-stage load/branch status and MEM-stage data-memory handshake, and drives the pipeline-register enables, flushes and bubbles. It sequences data-memory wait states with a timeout, and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for a 5-stage pipeline: hazard priority decode, data-memory
// wait-state tracking with timeout, and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal flow, no outstanding unacknowledged memory access
// MEM_WAIT | MEM-stage access outstanding, pipeline frozen until ack
// MEM_ERR  | memory timed out; pipeline halted until reset
module pipeline_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ID_rn,
    input  logic [3:0]  ID_rm,
    input  logic        ID_rn_used,
    input  logic        ID_rm_used,
    input  logic        EX_load_instr,
    input  logic        EX_RF_enable,
    input  logic [3:0]  EX_rd,
    input  logic        EX_B_instr,
    input  logic        EX_cond_true,
    input  logic        MEM_mem_instr,
    input  logic        dmem_ack,
    output logic        PC_enable,
    output logic        IF_ID_enable,
    output logic        ID_EX_enable,
    output logic        EX_MEM_enable,
    output logic        IF_ID_flush,
    output logic        ID_EX_bubble,
    output logic        MEM_WB_bubble,
    output logic        dmem_req,
    output logic        mem_error,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic memstall, taken, loaduse;

    always_comb begin
        memstall = MEM_mem_instr & ~dmem_ack;
        taken    = EX_B_instr & EX_cond_true;
        loaduse  = EX_load_instr & EX_RF_enable &
                   ((ID_rn_used & (ID_rn == EX_rd)) | (ID_rm_used & (ID_rm == EX_rd)));
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        PC_enable     = 1'b0;
        IF_ID_enable  = 1'b0;
        ID_EX_enable  = 1'b0;
        EX_MEM_enable = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        MEM_WB_bubble = 1'b0;
        dmem_req      = 1'b0;
        if (rst_n && state_q != MEM_ERR) begin
            dmem_req = MEM_mem_instr;
            if (memstall) begin
                MEM_WB_bubble = 1'b1;
            end else if (taken) begin
                PC_enable     = 1'b1;
                IF_ID_flush   = 1'b1;
                ID_EX_bubble  = 1'b1;
                EX_MEM_enable = 1'b1;
            end else if (loaduse) begin
                ID_EX_bubble  = 1'b1;
                EX_MEM_enable = 1'b1;
            end else begin
                PC_enable     = 1'b1;
                IF_ID_enable  = 1'b1;
                ID_EX_enable  = 1'b1;
                EX_MEM_enable = 1'b1;
            end
        end
    end

    // wait_cnt holds the number of unacked request cycles already elapsed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (memstall) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_W)
                        state_d = MEM_ERR;
                    else
                        state_d = MEM_WAIT;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            MEM_ERR: state_d = MEM_ERR;
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!PC_enable && state_q != MEM_ERR && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_error   = (state_q == MEM_ERR);
    assign stall_count = stall_count_q;

endmodule
